// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_e;

    localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs; flush takes priority over push and pop.
module fetch_fifo #(
    parameter int unsigned FIFO_DEPTH = 2,
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is data only; validity is tracked by count, so no reset here.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request at a time, prefetch FIFO toward the decoder.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    localparam int unsigned CW = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_e  state;
    logic [31:0]   fetch_addr;
    logic          pend_vld;
    logic [31:0]   pend_addr;
    logic [31:0]   target;
    logic          push;
    logic          pop;
    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] fifo_cnt_next;
    logic          fifo_full;
    logic          fifo_empty;
    logic [63:0]   fifo_head;
    logic          space_next;

    assign target = redirect_addr_i & INSTR_ALIGN_MASK;
    assign pop    = instr_valid_o & instr_ready_i;
    assign push   = (state == WAIT) & instr_rvalid_i & ~redirect_i & (~fifo_full | pop);

    assign fifo_cnt_next = redirect_i ? '0 : (fifo_cnt + CW'(push) - CW'(pop));
    assign space_next    = (fifo_cnt_next < DEPTH_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fetch_addr <= RESET_ADDR & INSTR_ALIGN_MASK;
            pend_vld   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_i) begin
                        fetch_addr <= target;
                        state      <= REQ;
                    end else if (space_next) begin
                        state <= REQ;
                    end
                end
                // Address stays put until granted; a redirect without grant waits in pend_*.
                REQ: begin
                    if (instr_gnt_i) begin
                        pend_vld <= 1'b0;
                        if (redirect_i) begin
                            fetch_addr <= target;
                            state      <= FLUSH;
                        end else if (pend_vld) begin
                            fetch_addr <= pend_addr;
                            state      <= FLUSH;
                        end else begin
                            fetch_addr <= fetch_addr + 32'd4;
                            state      <= WAIT;
                        end
                    end else if (redirect_i) begin
                        pend_vld <= 1'b1;
                    end
                end
                WAIT: begin
                    if (redirect_i) begin
                        fetch_addr <= target;
                        state      <= instr_rvalid_i ? REQ : FLUSH;
                    end else if (instr_rvalid_i) begin
                        state <= space_next ? REQ : IDLE;
                    end
                end
                FLUSH: begin
                    if (redirect_i)     fetch_addr <= target;
                    if (instr_rvalid_i) state      <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == REQ && !instr_gnt_i && redirect_i) pend_addr <= target;
    end

    // fetch_addr has already advanced past the word now returning.
    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .wdata ({fetch_addr - 32'd4, instr_rdata_i}),
        .rdata (fifo_head),
        .count (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign instr_req_o   = (state == REQ);
    assign instr_addr_o  = fetch_addr;
    assign instr_valid_o = ~fifo_empty;
    assign instr_o       = instr_valid_o ? fifo_head[31:0]  : 32'h0;
    assign instr_pc_o    = instr_valid_o ? fifo_head[63:32] : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scripted instruction-memory responder.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    int          nvec = 0;
    int          nerr = 0;
    bit          auto_mem;
    bit          mem_pend;
    logic [31:0] mem_addr;

    fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .instr_req_o     (instr_req_o),
        .instr_addr_o    (instr_addr_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .instr_valid_o   (instr_valid_o),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .instr_ready_i   (instr_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // One clock; in auto mode memory grants any request at once and answers next cycle.
    task automatic cycle();
        bit          g;
        logic [31:0] a;
        if (auto_mem) begin
            instr_gnt_i    = instr_req_o;
            instr_rvalid_i = mem_pend;
            instr_rdata_i  = mem_pend ? mem_data(mem_addr) : 32'h0;
        end
        g = auto_mem & instr_req_o;
        a = instr_addr_o;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            mem_pend = g;
            mem_addr = a;
        end
    endtask

    task automatic start_reset();
        rst_n           = 1'b0;
        redirect_i      = 1'b0;
        redirect_addr_i = 32'h0;
        instr_gnt_i     = 1'b0;
        instr_rvalid_i  = 1'b0;
        instr_rdata_i   = 32'h0;
        instr_ready_i   = 1'b0;
        auto_mem        = 1'b1;
        mem_pend        = 1'b0;
        mem_addr        = 32'h0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        start_reset();
        nvec++; if (instr_req_o !== 1'b0) begin nerr++; $display("FAIL rst_req got %b want 0", instr_req_o); end
        nvec++; if (instr_addr_o !== 32'h0) begin nerr++; $display("FAIL rst_addr got %h want 00000000", instr_addr_o); end
        nvec++; if (instr_valid_o !== 1'b0) begin nerr++; $display("FAIL rst_valid got %b want 0", instr_valid_o); end
        nvec++; if (instr_o !== 32'h0) begin nerr++; $display("FAIL rst_instr got %h want 00000000", instr_o); end
        nvec++; if (instr_pc_o !== 32'h0) begin nerr++; $display("FAIL rst_pc got %h want 00000000", instr_pc_o); end
        release_reset();
        cycle();
        nvec++; if (instr_req_o !== 1'b1) begin nerr++; $display("FAIL first_req got %b want 1", instr_req_o); end
        nvec++; if (instr_addr_o !== 32'h0) begin nerr++; $display("FAIL first_addr got %h want 00000000", instr_addr_o); end
    endtask

    task automatic test_sequential();
        int nreq = 0;
        int npop = 0;
        start_reset();
        release_reset();
        instr_ready_i = 1'b1;
        for (int i = 0; i < 30 && npop < 3; i++) begin
            cycle();
            if (instr_req_o && nreq < 3) begin
                nvec++; if (instr_addr_o !== 32'(4 * nreq)) begin nerr++; $display("FAIL seq_req_addr got %h want %h", instr_addr_o, 32'(4 * nreq)); end
                nreq++;
            end
            if (instr_valid_o) begin
                nvec++; if (instr_pc_o !== 32'(4 * npop)) begin nerr++; $display("FAIL seq_pc got %h want %h", instr_pc_o, 32'(4 * npop)); end
                nvec++; if (instr_o !== mem_data(32'(4 * npop))) begin nerr++; $display("FAIL seq_instr got %h want %h", instr_o, mem_data(32'(4 * npop))); end
                npop++;
            end
        end
        nvec++; if (nreq != 3) begin nerr++; $display("FAIL seq_nreq got %0d want 3", nreq); end
        nvec++; if (npop != 3) begin nerr++; $display("FAIL seq_npop got %0d want 3", npop); end
        instr_ready_i = 1'b0;
    endtask

    task automatic test_backpressure();
        int nreq = 0;
        start_reset();
        release_reset();
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (instr_req_o) nreq++;
        end
        nvec++; if (nreq != 2) begin nerr++; $display("FAIL bp_nreq got %0d want 2", nreq); end
        nvec++; if (instr_req_o !== 1'b0) begin nerr++; $display("FAIL bp_req_full got %b want 0", instr_req_o); end
        nvec++; if (instr_pc_o !== 32'h0) begin nerr++; $display("FAIL bp_head_pc got %h want 00000000", instr_pc_o); end
        nvec++; if (instr_o !== mem_data(32'h0)) begin nerr++; $display("FAIL bp_head_instr got %h want %h", instr_o, mem_data(32'h0)); end
        instr_ready_i = 1'b1;
        cycle();
        instr_ready_i = 1'b0;
        nvec++; if (instr_req_o !== 1'b1) begin nerr++; $display("FAIL bp_resume_req got %b want 1", instr_req_o); end
        nvec++; if (instr_addr_o !== 32'h8) begin nerr++; $display("FAIL bp_resume_addr got %h want 00000008", instr_addr_o); end
        nvec++; if (instr_pc_o !== 32'h4) begin nerr++; $display("FAIL bp_next_pc got %h want 00000004", instr_pc_o); end
        repeat (3) cycle();
        nvec++; if (instr_req_o !== 1'b0) begin nerr++; $display("FAIL bp_refull_req got %b want 0", instr_req_o); end
        nvec++; if (instr_pc_o !== 32'h4 || instr_o !== mem_data(32'h4)) begin nerr++; $display("FAIL bp_hold pc %h instr %h want 00000004 %h", instr_pc_o, instr_o, mem_data(32'h4)); end
    endtask

    task automatic test_redirect_wait();
        start_reset();
        release_reset();
        auto_mem = 1'b0;
        cycle();
        instr_gnt_i = 1'b1; cycle();
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h1111_0000; cycle();
        instr_rvalid_i = 1'b0; instr_gnt_i = 1'b1; cycle();
        instr_gnt_i = 1'b0;
        nvec++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h1111_0000) begin nerr++; $display("FAIL rw_pre valid %b instr %h want 1 11110000", instr_valid_o, instr_o); end
        redirect_i = 1'b1; redirect_addr_i = 32'h100; cycle();
        redirect_i = 1'b0;
        nvec++; if (instr_valid_o !== 1'b0) begin nerr++; $display("FAIL rw_flush_valid got %b want 0", instr_valid_o); end
        nvec++; if (instr_req_o !== 1'b0) begin nerr++; $display("FAIL rw_flush_req got %b want 0", instr_req_o); end
        cycle(); cycle();
        nvec++; if (instr_req_o !== 1'b0) begin nerr++; $display("FAIL rw_wait_req got %b want 0", instr_req_o); end
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'hBAD0_BAD0; cycle();
        instr_rvalid_i = 1'b0;
        nvec++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h100) begin nerr++; $display("FAIL rw_new_req req %b addr %h want 1 00000100", instr_req_o, instr_addr_o); end
        nvec++; if (instr_valid_o !== 1'b0) begin nerr++; $display("FAIL rw_dropped valid %b want 0", instr_valid_o); end
        instr_gnt_i = 1'b1; cycle();
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h2222_0100; cycle();
        instr_rvalid_i = 1'b0;
        nvec++; if (instr_pc_o !== 32'h100 || instr_o !== 32'h2222_0100) begin nerr++; $display("FAIL rw_new_data pc %h instr %h want 00000100 22220100", instr_pc_o, instr_o); end
    endtask

    task automatic test_redirect_req();
        start_reset();
        release_reset();
        auto_mem = 1'b0;
        cycle();
        redirect_i = 1'b1; redirect_addr_i = 32'h200; cycle();
        redirect_i = 1'b0;
        nvec++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin nerr++; $display("FAIL rr_hold1 req %b addr %h want 1 00000000", instr_req_o, instr_addr_o); end
        cycle();
        nvec++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin nerr++; $display("FAIL rr_hold2 req %b addr %h want 1 00000000", instr_req_o, instr_addr_o); end
        instr_gnt_i = 1'b1; cycle();
        instr_gnt_i = 1'b0;
        nvec++; if (instr_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin nerr++; $display("FAIL rr_flush req %b valid %b want 0 0", instr_req_o, instr_valid_o); end
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'hDEAD_0000; cycle();
        instr_rvalid_i = 1'b0;
        nvec++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h200) begin nerr++; $display("FAIL rr_new_req req %b addr %h want 1 00000200", instr_req_o, instr_addr_o); end
        nvec++; if (instr_valid_o !== 1'b0) begin nerr++; $display("FAIL rr_dropped valid %b want 0", instr_valid_o); end
        instr_gnt_i = 1'b1; cycle();
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h3333_0200; cycle();
        instr_rvalid_i = 1'b0;
        nvec++; if (instr_pc_o !== 32'h200 || instr_o !== 32'h3333_0200) begin nerr++; $display("FAIL rr_data pc %h instr %h want 00000200 33330200", instr_pc_o, instr_o); end
        nvec++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h204) begin nerr++; $display("FAIL rr_next req %b addr %h want 1 00000204", instr_req_o, instr_addr_o); end
    endtask

    task automatic test_wrap_align();
        start_reset();
        release_reset();
        instr_ready_i = 1'b1;
        redirect_i = 1'b1; redirect_addr_i = 32'hFFFF_FFFC; cycle();
        redirect_i = 1'b0;
        nvec++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL wrap_top req %b addr %h want 1 fffffffc", instr_req_o, instr_addr_o); end
        cycle(); cycle();
        nvec++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin nerr++; $display("FAIL wrap_zero req %b addr %h want 1 00000000", instr_req_o, instr_addr_o); end
        nvec++; if (instr_pc_o !== 32'hFFFF_FFFC || instr_o !== mem_data(32'hFFFF_FFFC)) begin nerr++; $display("FAIL wrap_data pc %h instr %h want fffffffc %h", instr_pc_o, instr_o, mem_data(32'hFFFF_FFFC)); end
        redirect_i = 1'b1; redirect_addr_i = 32'h103; cycle();
        redirect_i = 1'b0;
        nvec++; if (instr_valid_o !== 1'b0 || instr_req_o !== 1'b0) begin nerr++; $display("FAIL align_flush valid %b req %b want 0 0", instr_valid_o, instr_req_o); end
        cycle();
        nvec++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h100) begin nerr++; $display("FAIL align_addr req %b addr %h want 1 00000100", instr_req_o, instr_addr_o); end
        instr_ready_i = 1'b0;
    endtask

    task automatic test_async_reset();
        start_reset();
        release_reset();
        repeat (4) cycle();
        nvec++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0) begin nerr++; $display("FAIL ar_pre valid %b pc %h want 1 00000000", instr_valid_o, instr_pc_o); end
        rst_n = 1'b0;
        #1;
        nvec++; if (instr_req_o !== 1'b0 || instr_addr_o !== 32'h0) begin nerr++; $display("FAIL ar_req req %b addr %h want 0 00000000", instr_req_o, instr_addr_o); end
        nvec++; if (instr_valid_o !== 1'b0 || instr_o !== 32'h0 || instr_pc_o !== 32'h0) begin nerr++; $display("FAIL ar_out valid %b instr %h pc %h want 0 0 0", instr_valid_o, instr_o, instr_pc_o); end
        rst_n = 1'b1;
        cycle();
        nvec++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin nerr++; $display("FAIL ar_refetch req %b addr %h want 1 00000000", instr_req_o, instr_addr_o); end
        nvec++; if (instr_valid_o !== 1'b0) begin nerr++; $display("FAIL ar_stale valid %b want 0", instr_valid_o); end
        cycle(); cycle();
        nvec++; if (instr_pc_o !== 32'h0 || instr_o !== mem_data(32'h0)) begin nerr++; $display("FAIL ar_data pc %h instr %h want 00000000 %h", instr_pc_o, instr_o, mem_data(32'h0)); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_req();
        test_wrap_align();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
